// File: rtl/regfile_pkg.sv
// Shared defaults and port-slice helper for the parametrised register file
// and its scoreboard.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int NREAD_DEF = 2;

   // Low bit of port 'port' inside a flattened bus of 'width'-bit slices.
   function automatic int slice_lo(input int port, input int width);
      return port * width;
   endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Read/write/reserve bus between the decode stage and the register file.
interface regfile_sb_if
   import regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NREAD = NREAD_DEF
);
   localparam int AW = $clog2(NREGS);

   logic [NREAD*AW-1:0]   ra;
   logic [NREAD*XLEN-1:0] rd;
   logic [NREAD-1:0]      rbusy;
   logic                  we;
   logic [AW-1:0]         wa;
   logic [XLEN-1:0]       wd;
   logic                  rsv;
   logic [AW-1:0]         rsv_a;
   logic                  flush;
   logic [NREGS-1:0]      busy_vec;

   modport master (
      output ra, we, wa, wd, rsv, rsv_a, flush,
      input  rd, rbusy, busy_vec
   );

   modport slave (
      input  ra, we, wa, wd, rsv, rsv_a, flush,
      output rd, rbusy, busy_vec
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// One busy bit per register: set on reserve, cleared by the retiring write,
// wiped by a pipeline flush.
module regfile_scoreboard #(
   parameter int NREGS    = 32,
   parameter bit ZERO_REG = 1'b1,
   parameter int AW       = $clog2(NREGS)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             rsv_i,
   input  logic [AW-1:0]    rsv_a_i,
   input  logic             we_i,
   input  logic [AW-1:0]    wa_i,
   input  logic             flush_i,
   output logic [NREGS-1:0] busy_vec_o
);

   logic [NREGS-1:0] busy_q, busy_d;
   logic [NREGS-1:0] set_v, clr_v;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      set_v = '0;
      clr_v = '0;
      if (rsv_i && !flush_i) set_v[rsv_a_i] = 1'b1;
      if (we_i)              clr_v[wa_i]    = 1'b1;
      // A write retires the older producer; a same-cycle reserve keeps the new one pending.
      busy_d = flush_i ? '0 : (set_v | (busy_q & ~clr_v));
      if (ZERO_REG) busy_d[0] = 1'b0;
   end

   // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) busy_q <= '0;
      else       busy_q <= busy_d;
   end

   assign busy_vec_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with write-through bypass and a pending-write
// scoreboard feeding the hazard unit.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREGS    = NREGS_DEF,
   parameter int NREAD    = NREAD_DEF,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic         clock,
   input  logic         reset,
   regfile_sb_if.slave  bus
);

   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]       regs_q [NREGS];
   logic [NREGS-1:0]      busy;
   logic                  wr_en;
   logic [AW-1:0]         raddr  [NREAD];
   logic [NREAD-1:0]      hit;
   logic [NREAD-1:0]      is_zero;
   logic [NREAD*XLEN-1:0] rd_pack;
   logic [NREAD-1:0]      rbusy_pack;

   assign wr_en = bus.we && !(ZERO_REG && bus.wa == '0);

   // NOTE: the array is reset explicitly because reads must return 0 after reset, so it maps to flops, not RAM.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int n = 0; n < NREGS; n++) regs_q[n] <= '0;
      end else if (wr_en) begin
         regs_q[bus.wa] <= bus.wd;
      end
   end

   regfile_scoreboard #(
      .NREGS    (NREGS),
      .ZERO_REG (ZERO_REG),
      .AW       (AW)
   ) u_scoreboard (
      .clock      (clock),
      .reset      (reset),
      .rsv_i      (bus.rsv),
      .rsv_a_i    (bus.rsv_a),
      .we_i       (bus.we),
      .wa_i       (bus.wa),
      .flush_i    (bus.flush),
      .busy_vec_o (busy)
   );

   // Bypass is suppressed while reset is held so outputs stay zero throughout reset.
   always_comb begin
      rd_pack    = '0;
      rbusy_pack = '0;
      for (int i = 0; i < NREAD; i++) begin
         raddr[i]   = bus.ra[slice_lo(i, AW) +: AW];
         is_zero[i] = ZERO_REG && raddr[i] == '0;
         hit[i]     = !reset && bus.we && bus.wa == raddr[i];
         if (is_zero[i]) begin
            rd_pack[slice_lo(i, XLEN) +: XLEN] = '0;
            rbusy_pack[i]                      = 1'b0;
         end else begin
            rd_pack[slice_lo(i, XLEN) +: XLEN] = hit[i] ? bus.wd : regs_q[raddr[i]];
            rbusy_pack[i]                      = busy[raddr[i]] && !hit[i];
         end
      end
   end

   assign bus.rd       = rd_pack;
   assign bus.rbusy    = rbusy_pack;
   assign bus.busy_vec = busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench: directed scenarios on three configurations plus a
// randomized run on the 3-port/16-entry/16-bit variant against a reference model.
module tb_regfile_sb;

   logic clk;
   logic rst;

   regfile_sb_if                                   if_a ();
   regfile_sb_if                                   if_b ();
   regfile_sb_if #(.XLEN(16), .NREGS(16), .NREAD(3)) if_c ();

   regfile_sb #(.ZERO_REG(1'b1)) dut_a (.clock(clk), .reset(rst), .bus(if_a.slave));
   regfile_sb #(.ZERO_REG(1'b0)) dut_b (.clock(clk), .reset(rst), .bus(if_b.slave));
   regfile_sb #(.XLEN(16), .NREGS(16), .NREAD(3), .ZERO_REG(1'b1))
      dut_c (.clock(clk), .reset(rst), .bus(if_c.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_all();
      if_a.ra = '0; if_a.we = 0; if_a.wa = '0; if_a.wd = '0;
      if_a.rsv = 0; if_a.rsv_a = '0; if_a.flush = 0;
      if_b.ra = '0; if_b.we = 0; if_b.wa = '0; if_b.wd = '0;
      if_b.rsv = 0; if_b.rsv_a = '0; if_b.flush = 0;
      if_c.ra = '0; if_c.we = 0; if_c.wa = '0; if_c.wd = '0;
      if_c.rsv = 0; if_c.rsv_a = '0; if_c.flush = 0;
   endtask

   // Reference model for the 16x16, 3-port, zero-register configuration.
   logic [15:0] m_regs [16];
   logic        m_busy [16];

   task automatic random_run(input int cycles);
      logic [3:0]  a;
      logic [15:0] exp_rd;
      logic        exp_busy;
      logic [15:0] exp_bv;
      for (int n = 0; n < 16; n++) begin
         m_regs[n] = '0;
         m_busy[n] = 1'b0;
      end
      for (int c = 0; c < cycles; c++) begin
         if_c.we    = ($urandom_range(0, 2) == 0);
         if_c.wa    = 4'($urandom_range(0, 15));
         if_c.wd    = 16'($urandom);
         if_c.rsv   = ($urandom_range(0, 2) == 0);
         if_c.rsv_a = 4'($urandom_range(0, 15));
         if_c.flush = ($urandom_range(0, 15) == 0);
         for (int p = 0; p < 3; p++) begin
            // Bias reads toward recently touched registers to provoke bypass and busy hits.
            case ($urandom_range(0, 3))
               0:       if_c.ra[p*4 +: 4] = if_c.wa;
               1:       if_c.ra[p*4 +: 4] = if_c.rsv_a;
               default: if_c.ra[p*4 +: 4] = 4'($urandom_range(0, 15));
            endcase
         end
         settle();
         for (int p = 0; p < 3; p++) begin
            a = if_c.ra[p*4 +: 4];
            if (a == 0) begin
               exp_rd   = '0;
               exp_busy = 1'b0;
            end else if (if_c.we && if_c.wa == a) begin
               exp_rd   = if_c.wd;
               exp_busy = 1'b0;
            end else begin
               exp_rd   = m_regs[a];
               exp_busy = m_busy[a];
            end
            check($sformatf("rand c%0d rd%0d", c, p), 64'(if_c.rd[p*16 +: 16]), 64'(exp_rd));
            check($sformatf("rand c%0d rbusy%0d", c, p), 64'(if_c.rbusy[p]), 64'(exp_busy));
         end
         for (int n = 0; n < 16; n++) exp_bv[n] = m_busy[n];
         check($sformatf("rand c%0d busy_vec", c), 64'(if_c.busy_vec), 64'(exp_bv));
         if (if_c.we && if_c.wa != 0) m_regs[if_c.wa] = if_c.wd;
         if (if_c.flush) begin
            for (int n = 0; n < 16; n++) m_busy[n] = 1'b0;
         end else begin
            if (if_c.we && if_c.wa != 0)       m_busy[if_c.wa]    = 1'b0;
            if (if_c.rsv && if_c.rsv_a != 0)   m_busy[if_c.rsv_a] = 1'b1;
         end
         tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_all();
      if_a.ra = {5'd5, 5'd5};
      #3;
      check("reset rd_a",       64'(if_a.rd),       64'h0);
      check("reset rbusy_a",    64'(if_a.rbusy),    64'h0);
      check("reset busy_vec_a", 64'(if_a.busy_vec), 64'h0);
      check("reset busy_vec_c", 64'(if_c.busy_vec), 64'h0);
      tick();
      rst = 1'b0;
      tick();

      // Mid-run async reset after writing r5.
      if_a.we = 1; if_a.wa = 5; if_a.wd = 32'hDEADBEEF;
      if_a.rsv = 1; if_a.rsv_a = 6;
      tick();
      idle_all();
      if_a.ra = {5'd6, 5'd5};
      settle();
      check("pre-reset rd r5",      64'(if_a.rd[31:0]),    64'hDEADBEEF);
      check("pre-reset busy_vec",   64'(if_a.busy_vec),    64'h40);
      check("pre-reset rbusy r6",   64'(if_a.rbusy[1]),    64'h1);
      if_a.we = 1; if_a.wa = 5; if_a.wd = 32'hAAAA5555;
      if_a.rsv = 1; if_a.rsv_a = 5;
      #1 rst = 1'b1;
      #1;
      check("reset async rd r5",    64'(if_a.rd[31:0]),    64'h0);
      check("reset async busy_vec", 64'(if_a.busy_vec),    64'h0);
      check("reset async rbusy",    64'(if_a.rbusy),       64'h0);
      tick();
      rst = 1'b0;
      idle_all();
      if_a.ra = {5'd6, 5'd5};
      settle();
      check("post-reset rd r5",       64'(if_a.rd[31:0]), 64'h0);
      check("post-reset busy_vec",    64'(if_a.busy_vec), 64'h0);
      tick();

      // Same-cycle bypass, then registered read; two ports on the same register.
      if_a.ra = {5'd7, 5'd7};
      if_a.we = 1; if_a.wa = 7; if_a.wd = 32'h12345678;
      settle();
      check("bypass rd0 r7", 64'(if_a.rd[31:0]),  64'h12345678);
      check("bypass rd1 r7", 64'(if_a.rd[63:32]), 64'h12345678);
      tick();
      if_a.we = 0;
      settle();
      check("stored rd0 r7", 64'(if_a.rd[31:0]), 64'h12345678);

      // Register 0 handling with and without the hardwired zero.
      if_a.ra = '0; if_a.we = 1; if_a.wa = 0; if_a.wd = 32'hFFFFFFFF;
      if_a.rsv = 1; if_a.rsv_a = 0;
      if_b.ra = '0; if_b.we = 1; if_b.wa = 0; if_b.wd = 32'hFFFFFFFF;
      if_b.rsv = 1; if_b.rsv_a = 0;
      settle();
      check("zreg rd0 same cycle",   64'(if_a.rd[31:0]), 64'h0);
      check("zreg rbusy0",           64'(if_a.rbusy[0]), 64'h0);
      check("nozreg bypass rd0",     64'(if_b.rd[31:0]), 64'hFFFFFFFF);
      tick();
      idle_all();
      settle();
      check("zreg rd0 stored",       64'(if_a.rd[31:0]),   64'h0);
      check("zreg busy_vec0",        64'(if_a.busy_vec[0]), 64'h0);
      check("zreg rbusy0 stored",    64'(if_a.rbusy[0]),    64'h0);
      check("nozreg rd0 stored",     64'(if_b.rd[31:0]),   64'hFFFFFFFF);
      check("nozreg busy_vec0",      64'(if_b.busy_vec[0]), 64'h1);
      check("nozreg rbusy0",         64'(if_b.rbusy[0]),    64'h1);

      // Reserve r3, retire it four cycles later.
      if_a.ra = {5'd0, 5'd3};
      if_a.rsv = 1; if_a.rsv_a = 3;
      settle();
      check("rsv r3 not yet visible", 64'(if_a.rbusy[0]), 64'h0);
      tick();
      if_a.rsv = 0;
      settle();
      check("rsv r3 busy_vec c1", 64'(if_a.busy_vec[3]), 64'h1);
      check("rsv r3 rbusy c1",    64'(if_a.rbusy[0]),    64'h1);
      tick();
      tick();
      tick();
      if_a.we = 1; if_a.wa = 3; if_a.wd = 32'hA5;
      settle();
      check("retire r3 rbusy c4",    64'(if_a.rbusy[0]),    64'h0);
      check("retire r3 rd c4",       64'(if_a.rd[31:0]),    64'hA5);
      check("retire r3 busy_vec c4", 64'(if_a.busy_vec[3]), 64'h1);
      tick();
      if_a.we = 0;
      settle();
      check("retire r3 busy_vec c5", 64'(if_a.busy_vec[3]), 64'h0);
      check("retire r3 rd c5",       64'(if_a.rd[31:0]),    64'hA5);

      // Reserve and write the same register: set wins, data still lands.
      if_a.ra = {5'd9, 5'd0};
      if_a.rsv = 1; if_a.rsv_a = 9;
      if_a.we = 1; if_a.wa = 9; if_a.wd = 32'h55;
      tick();
      idle_all();
      if_a.ra = {5'd9, 5'd0};
      settle();
      check("set-wins rd r9",     64'(if_a.rd[63:32]),  64'h55);
      check("set-wins busy_vec",  64'(if_a.busy_vec),   64'h200);
      check("set-wins rbusy r9",  64'(if_a.rbusy[1]),   64'h1);
      if_a.flush = 1; if_a.rsv = 1; if_a.rsv_a = 10;
      if_a.we = 1; if_a.wa = 11; if_a.wd = 32'h77;
      tick();
      idle_all();
      if_a.ra = {5'd10, 5'd11};
      settle();
      check("flush busy_vec",     64'(if_a.busy_vec),  64'h0);
      check("flush write r11",    64'(if_a.rd[31:0]),  64'h77);
      check("flush rbusy r10",    64'(if_a.rbusy[1]),  64'h0);

      // Three ports on one register during a bypassed write.
      if_c.ra = {4'd4, 4'd4, 4'd4};
      if_c.we = 1; if_c.wa = 4; if_c.wd = 16'hBEEF;
      settle();
      for (int p = 0; p < 3; p++)
         check($sformatf("3port bypass rd%0d", p), 64'(if_c.rd[p*16 +: 16]), 64'hBEEF);
      tick();
      idle_all();

      // Reset C so the model starts from a known zero state.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      random_run(400);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the fixed 32x32 MIPS register file. It supports a configurable number of registers, data width and read-port count. It adds a write-through bypass and a per-register scoreboard of pending writes for multi-cycle producers such as loads and mul/div. It sits in the decode stage of the pipelined MIPS core and feeds operands plus stall information to the hazard unit.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >=2)
NREAD, 2, number of combinational read ports
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/reservations; 0 = register 0 is ordinary
AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
ra  in  NREAD*AW  read addresses; port i at bits [i*AW +: AW]
rd  out  NREAD*XLEN  read data; port i at bits [i*XLEN +: XLEN]
rbusy  out  NREAD  port i's register has a pending (reserved, unwritten) write
we  in  1  write enable
wa  in  AW  write address
wd  in  XLEN  write data
rsv  in  1  reserve: mark register rsv_a as pending
rsv_a  in  AW  register to reserve
flush  in  1  clear all reservations (pipeline flush)
busy_vec  out  NREGS  full scoreboard state, bit n = register n pending

Behaviour:
- Reset (async, active-high): all registers clear to 0 and all busy bits clear. Outputs during and after reset: rd=0, rbusy=0, busy_vec=0. Reset asserted mid-operation discards any write or reserve in that cycle.
- Storage: NREGS x XLEN flops. A write takes effect at the clock edge when we=1.
- Read: combinational, zero latency. rd[i] = regs[ra[i]], with these overrides:
  - ZERO_REG=1 and ra[i]==0 -> rd[i]=0, rbusy[i]=0.
  - Bypass: we=1 and wa==ra[i] (and not the zero register) -> rd[i]=wd in the same cycle.
- rbusy[i] = busy[ra[i]] & ~(we & wa==ra[i]). A same-cycle write completes the pending value, so the consumer does not stall. Exception: rsv=1 with rsv_a==ra[i] in that cycle does not affect rbusy combinationally; the new reservation is visible next cycle.
- Scoreboard update, per register n, at each clock edge:
  - set = rsv & rsv_a==n & ~flush
  - clr = we & wa==n
  - busy_n' = flush ? 0 : (set ? 1 : (clr ? 0 : busy_n))
  - If set and clr hit the same register in the same cycle, set wins: the write retires the older producer and the new producer stays pending.
  - flush overrides set. A write in a flush cycle still updates the register data.
- ZERO_REG=1: writes, reservations and busy for register 0 are ignored; busy_vec[0] stays 0.
- Writing a non-reserved register is legal: data updates, busy stays 0.
- Reserving an already-busy register is legal: it stays busy (no counting; one outstanding producer per register).
- Multiple read ports may address the same register; each resolves independently.
- Out-of-range addresses cannot occur because NREGS is a power of two.

Decomposition:
- Package regfile_pkg holds the default XLEN/NREGS/NREAD constants and a helper function for the port-slice offsets.
- One sub-module, regfile_scoreboard: NREGS busy bits, set/clear/flush logic, busy_vec output.
- Data array, bypass and read muxing stay in regfile_sb.
- The read mux is an indexed array read, not an explicit tree.

Test Plan:
1. Assert reset mid-run after writing 0xDEADBEEF to r5 -> rd for ra=5 is 0 immediately (async); busy_vec=0.
2. we=1, wa=7, wd=0x12345678, ra0=7 in the same cycle -> rd0=0x12345678 combinationally; next cycle with we=0, rd0 still reads 0x12345678.
3. ZERO_REG=1: write 0xFFFFFFFF to r0 and rsv r0 -> rd=0, rbusy=0, busy_vec[0]=0. Repeat with ZERO_REG=0 -> rd=0xFFFFFFFF.
4. rsv r3 at cycle 0 -> busy_vec[3]=1 from cycle 1. At cycle 4, we r3=0xA5 -> rbusy for ra=3 is 0 in cycle 4, rd=0xA5; busy_vec[3]=0 from cycle 5.
5. Same cycle: rsv r9, we r9=0x55 -> r9=0x55 and busy_vec[9]=1 next cycle. Then flush together with rsv r10 -> busy_vec all 0.
6. NREAD=3, NREGS=16, XLEN=16: all three ports read r4 during a bypassed write of 0xBEEF -> every rd slice = 0xBEEF. A random write/read/reserve sequence matches a scoreboard model.
